// File: rtl/spad_pixel_collector.sv
// spad_pixel_collector: pairs low/high SPAD row-group bytes into 16-bit pixels,
// buffers them in a FWFT FIFO and streams them out with frame/drop/sync statistics.
module spad_pixel_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReadEnable,
  input  logic             HighLowRows,
  input  logic [2:0]       RowSelect,
  input  logic [5:0]       ColSelect,
  input  logic [7:0]       PixelData,
  output logic [15:0]      m_tdata,
  output logic [8:0]       m_tuser,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] sync_err_count,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, HAVE_LOW} state_t;
  state_t       r_state;
  logic         r_re_d;
  logic [7:0]   r_cap_data;
  logic         r_cap_hl;
  logic [8:0]   r_cap_addr;
  logic [7:0]   r_low_data;
  logic [8:0]   r_low_addr;
  logic [25:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]  r_count;
  logic         w_commit;
  logic         w_pair;
  logic         w_err;
  logic         w_pop;
  logic         w_accept;
  logic         w_drop;
  logic         w_last;
  logic [25:0]  w_word;
  assign w_commit = r_re_d & ~ReadEnable;
  assign w_pair   = w_commit & (r_state == HAVE_LOW) & r_cap_hl & (r_cap_addr == r_low_addr);
  // A high byte is only good if it closes an open low at the same address
  assign w_err    = w_commit & (r_cap_hl ? ((r_state == IDLE) | (r_cap_addr != r_low_addr))
                                         : (r_state == HAVE_LOW));
  assign w_last   = r_low_addr == 9'd511;
  assign w_word   = {r_cap_data, r_low_data, r_low_addr, w_last};
  assign m_tvalid = r_count != '0;
  assign w_pop    = m_tvalid & m_tready;
  assign w_accept = w_pair & ((r_count != DEPTH_C) | w_pop);
  assign w_drop   = w_pair & ~w_accept;
  assign {m_tdata, m_tuser, m_tlast} = r_mem[r_rd_ptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_re_d     <= 1'b0;
      r_cap_data <= '0;
      r_cap_hl   <= 1'b0;
      r_cap_addr <= '0;
    end else begin
      r_re_d <= ReadEnable;
      if (ReadEnable) r_cap_data <= PixelData;
      if (ReadEnable && !r_re_d) begin
        r_cap_hl   <= HighLowRows;
        r_cap_addr <= {RowSelect, ColSelect};
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_low_data <= '0;
      r_low_addr <= '0;
    end else if (w_commit && !r_cap_hl) begin
      r_low_data <= r_cap_data;
      r_low_addr <= r_cap_addr;
      r_state    <= HAVE_LOW;
    end else if (w_commit) begin
      r_state <= IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_accept} - {{AW{1'b0}}, w_pop};
    end
  end
  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count    <= '0;
      drop_count     <= '0;
      sync_err_count <= '0;
      overflow       <= 1'b0;
    end else if (clear_stats) begin
      frame_count    <= '0;
      drop_count     <= '0;
      sync_err_count <= '0;
      overflow       <= 1'b0;
    end else begin
      if (w_accept && w_last && frame_count != '1) frame_count <= frame_count + CNT_W'(1);
      if (w_drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      if (w_err && sync_err_count != '1) sync_err_count <= sync_err_count + CNT_W'(1);
      if (w_drop) overflow <= 1'b1;
    end
  end
endmodule
